// File: rtl/rename_map_table.sv
// rename_map_table: speculative register alias table with intra-group bypass and branch checkpoints
module rename_map_table #(
   parameter int WIDTH = 4,
   parameter int AREGS = 32,
   parameter int PW    = 6,
   parameter int NCKPT = 4,
   localparam int AW   = $clog2(AREGS),
   localparam int CW   = $clog2(NCKPT)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH*AW-1:0] rs1,
   input  logic [WIDTH*AW-1:0] rs2,
   input  logic [WIDTH*AW-1:0] dest,
   input  logic [WIDTH-1:0]    dest_we,
   input  logic [WIDTH*PW-1:0] new_preg,
   output logic [WIDTH*PW-1:0] prs1,
   output logic [WIDTH*PW-1:0] prs2,
   output logic [WIDTH*PW-1:0] old_preg,
   input  logic                ckpt_req,
   output logic [CW-1:0]       ckpt_id,
   output logic                ckpt_full,
   input  logic                br_release,
   input  logic                br_restore,
   input  logic [CW-1:0]       br_id
);
   logic [PW-1:0] r_map [AREGS];
   logic [PW-1:0] r_slot [NCKPT][AREGS];
   logic [CW-1:0] r_head, r_tail;
   logic [CW:0]   r_count;
   logic [AW-1:0] w_rs1 [WIDTH];
   logic [AW-1:0] w_rs2 [WIDTH];
   logic [AW-1:0] w_dst [WIDTH];
   logic [PW-1:0] w_new [WIDTH];
   logic [PW-1:0] w_p1 [WIDTH];
   logic [PW-1:0] w_p2 [WIDTH];
   logic [PW-1:0] w_po [WIDTH];
   logic [PW-1:0] w_nmap [AREGS];
   logic [WIDTH-1:0] w_we;
   logic          w_acc, w_take, w_rel;
   logic [CW-1:0] w_head_n;

   // Lanes writing register 0 are excluded so x0 never bypasses or updates the map
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      assign w_rs1[i] = rs1[i*AW +: AW];
      assign w_rs2[i] = rs2[i*AW +: AW];
      assign w_dst[i] = dest[i*AW +: AW];
      assign w_new[i] = new_preg[i*PW +: PW];
      assign w_we[i]  = dest_we[i] && w_dst[i] != '0;
      assign prs1[i*PW +: PW]     = w_p1[i];
      assign prs2[i*PW +: PW]     = w_p2[i];
      assign old_preg[i*PW +: PW] = w_po[i];
   end

   assign ckpt_full = r_count == (CW+1)'(NCKPT);
   assign in_ready  = !br_restore && !(ckpt_req && ckpt_full);
   assign ckpt_id   = r_tail;
   assign w_acc     = in_valid && in_ready;
   assign w_take    = w_acc && ckpt_req;
   assign w_rel     = br_release && r_count != '0;
   assign w_head_n  = r_head + CW'(w_rel);

   // Source and old-dest lookup: table value overridden by the youngest older lane writing it
   always_comb begin
      for (int k = 0; k < WIDTH; k++) begin
         w_p1[k] = r_map[w_rs1[k]];
         w_p2[k] = r_map[w_rs2[k]];
         w_po[k] = r_map[w_dst[k]];
         for (int j = 0; j < k; j++) begin
            if (w_we[j] && w_dst[j] == w_rs1[k]) w_p1[k] = w_new[j];
            if (w_we[j] && w_dst[j] == w_rs2[k]) w_p2[k] = w_new[j];
            if (w_we[j] && w_dst[j] == w_dst[k]) w_po[k] = w_new[j];
         end
      end
   end

   // Map after this group's writes; later lanes overwrite earlier ones
   always_comb begin
      w_nmap = r_map;
      for (int k = 0; k < WIDTH; k++)
         if (w_we[k]) w_nmap[w_dst[k]] = w_new[k];
   end

   // Live map: restore from a checkpoint on mispredict, otherwise commit the accepted group
   always_ff @(posedge clk or posedge rst) begin
      if (rst) for (int i = 0; i < AREGS; i++) r_map[i] <= PW'(i);
      else if (br_restore) r_map <= r_slot[br_id];
      else if (w_acc) r_map <= w_nmap;
   end

   // Checkpoint storage holds the post-group map; contents are meaningless until taken
   always_ff @(posedge clk) begin
      if (w_take) r_slot[r_tail] <= w_nmap;
   end

   // Circular buffer pointers; restore keeps the restored slot and drops all younger ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head <= w_head_n;
         if (br_restore) begin
            r_tail  <= br_id + 1'b1;
            r_count <= {1'b0, CW'(br_id - w_head_n)} + 1'b1;
         end else begin
            r_tail  <= r_tail + CW'(w_take);
            r_count <= r_count + (CW+1)'(w_take) - (CW+1)'(w_rel);
         end
      end
   end
endmodule

// File: tb/tb_rename_map_table.sv
// tb_rename_map_table: randomized scoreboard bench against a sequential-rename reference model
module tb_rename_map_table;
   logic        clk = 0, rst = 1;
   logic        in_valid = 0, ckpt_req = 0, br_release = 0, br_restore = 0;
   logic [19:0] rs1 = 0, rs2 = 0, dest = 0;
   logic [3:0]  dest_we = 0;
   logic [23:0] new_preg = 0;
   logic [1:0]  br_id = 0;
   logic        in_ready, ckpt_full;
   logic [23:0] prs1, prs2, old_preg;
   logic [1:0]  ckpt_id;

   rename_map_table dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .rs1(rs1), .rs2(rs2), .dest(dest), .dest_we(dest_we), .new_preg(new_preg),
      .prs1(prs1), .prs2(prs2), .old_preg(old_preg),
      .ckpt_req(ckpt_req), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
      .br_release(br_release), .br_restore(br_restore), .br_id(br_id)
   );

   always #5 clk = ~clk;

   typedef logic [31:0][5:0] map_t;
   typedef struct packed {
      logic [23:0] p1, p2, po;
      logic        rdy, full;
      logic [1:0]  id;
   } exp_t;

   map_t m;
   map_t cq[$];
   exp_t sq[$];
   int   head, tail;
   int   checks = 0, errors = 0;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got=%h want=%h at %0t", n, a, e, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m[i] = 6'(i);
      cq.delete();
      head = 0;
      tail = 0;
   endfunction

   function automatic logic [19:0] l5(input int a0, a1, a2, a3);
      return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
   endfunction

   function automatic logic [23:0] l6(input int a0, a1, a2, a3);
      return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
   endfunction

   // Rename each lane in order against a working copy of the map, then apply branch bookkeeping
   task automatic step(input logic v, input logic [19:0] a, b, d, input logic [3:0] we,
                       input logic [23:0] np, input logic cr, rl, rs, input logic [1:0] bi);
      exp_t e;
      map_t t;
      logic acc;
      int   cnt, pos;
      @(posedge clk);
      #1;
      in_valid = v; rs1 = a; rs2 = b; dest = d; dest_we = we; new_preg = np;
      ckpt_req = cr; br_release = rl; br_restore = rs; br_id = bi;
      cnt = cq.size();
      t = m;
      e = '0;
      for (int k = 0; k < 4; k++) begin
         e.p1[k*6 +: 6] = t[a[k*5 +: 5]];
         e.p2[k*6 +: 6] = t[b[k*5 +: 5]];
         e.po[k*6 +: 6] = t[d[k*5 +: 5]];
         if (we[k] && d[k*5 +: 5] != 0) t[d[k*5 +: 5]] = np[k*6 +: 6];
      end
      e.rdy  = !rs && !(cr && cnt == 4);
      e.full = cnt == 4;
      e.id   = 2'(tail);
      sq.push_back(e);
      acc = v && e.rdy;
      if (acc) m = t;
      if (acc && cr) begin
         cq.push_back(t);
         tail = (tail + 1) % 4;
      end
      if (rl && cnt > 0) begin
         void'(cq.pop_front());
         head = (head + 1) % 4;
      end
      if (rs) begin
         pos = (int'(bi) - head + 4) % 4;
         m = cq[pos];
         while (cq.size() > pos + 1) void'(cq.pop_back());
         tail = (int'(bi) + 1) % 4;
      end
   endtask

   function automatic logic [4:0] pick();
      return ($urandom % 4 == 0) ? 5'($urandom) : 5'($urandom % 8);
   endfunction

   task automatic rand_step();
      int cnt, c2, r;
      logic rl, rs;
      logic [1:0] bi;
      logic [19:0] a, b, d;
      cnt = cq.size();
      rl  = ($urandom % 4) == 0;
      r   = (rl && cnt > 0) ? 1 : 0;
      c2  = cnt - r;
      rs  = c2 > 0 && ($urandom % 8) == 0;
      bi  = 2'(head + r + (rs ? int'($urandom % c2) : 0));
      for (int k = 0; k < 4; k++) begin
         a[k*5 +: 5] = pick();
         b[k*5 +: 5] = pick();
         d[k*5 +: 5] = pick();
      end
      step(($urandom % 8) != 0, a, b, d, 4'($urandom), 24'($urandom),
           ($urandom % 3) == 0, rl, rs, bi);
   endtask

   task automatic async_reset_check();
      @(posedge clk);
      #1;
      in_valid = 0; ckpt_req = 0; br_release = 0; br_restore = 0; dest_we = 0;
      rs1 = l5(7, 0, 0, 0);
      #1 chk("pre_rst_map7", 64'(prs1[5:0]), 64'd60);
      rst = 1;
      #1 chk("rst_map7", 64'(prs1[5:0]), 64'd7);
      chk("rst_full", 64'(ckpt_full), 64'd0);
      chk("rst_id", 64'(ckpt_id), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      #1 rst = 0;
      model_reset();
   endtask

   // Monitor: every presented group is compared against the oldest queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sq.size() != 0) begin
            e = sq.pop_front();
            chk("prs1", 64'(prs1), 64'(e.p1));
            chk("prs2", 64'(prs2), 64'(e.p2));
            chk("old_preg", 64'(old_preg), 64'(e.po));
            chk("in_ready", 64'(in_ready), 64'(e.rdy));
            chk("ckpt_full", 64'(ckpt_full), 64'(e.full));
            chk("ckpt_id", 64'(ckpt_id), 64'(e.id));
         end
      end
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 0;
      #1 chk("reset_ready", 64'(in_ready), 64'd1);
      chk("reset_full", 64'(ckpt_full), 64'd0);
      step(1, l5(5, 0, 1, 2), l5(31, 3, 4, 0), 0, 0, 0, 0, 0, 0, 0);
      step(1, l5(0, 0, 0, 3), 0, l5(3, 9, 3, 10), 4'hF, l6(40, 20, 41, 21), 0, 0, 0, 0);
      step(1, l5(3, 9, 10, 0), 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, l5(0, 0, 0, 0), 0, l5(0, 0, 0, 0), 4'b0001, l6(50, 0, 0, 0), 0, 0, 0, 0);
      step(1, l5(0, 0, 0, 0), 0, l5(0, 0, 0, 0), 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, l5(4, 0, 0, 0), 4'b0001, l6(44, 0, 0, 0), 1, 0, 0, 0);
      step(1, l5(4, 0, 0, 0), 0, l5(4, 0, 0, 0), 4'b0001, l6(45, 0, 0, 0), 0, 0, 0, 0);
      step(1, l5(4, 0, 0, 0), 0, l5(4, 0, 0, 0), 4'b0001, l6(46, 0, 0, 0), 0, 0, 1, 0);
      step(1, l5(4, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++)
         step(1, 0, 0, l5(11 + i, 0, 0, 0), 4'b0001, l6(30 + i, 0, 0, 0), 1, 0, 0, 0);
      step(1, 0, 0, l5(4, 0, 0, 0), 4'b0001, l6(60, 0, 0, 0), 1, 0, 0, 0);
      step(1, l5(4, 0, 0, 0), 0, l5(4, 0, 0, 0), 4'b0001, l6(61, 0, 0, 0), 1, 1, 0, 0);
      step(1, l5(4, 0, 0, 0), 0, l5(5, 0, 0, 0), 4'b0001, l6(62, 0, 0, 0), 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      step(1, 0, 0, l5(7, 0, 0, 0), 4'b0001, l6(60, 0, 0, 0), 1, 0, 0, 0);
      step(1, l5(7, 0, 0, 0), 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, l5(7, 0, 0, 0), 0, 0, 0, 0, 1, 0, 0, 0);
      async_reset_check();
      for (int i = 0; i < 4; i++) step(1, l5(7, 0, 0, 0), 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, l5(7, 0, 0, 0), 0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 800; i++) rand_step();
      @(posedge clk);
      #1 in_valid = 0;
      for (int i = 0; i < 10 && sq.size() != 0; i++) @(negedge clk);
      if (sq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d want=0", sq.size());
      end
      #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rename_map_table.md
Name: rename_map_table

Overview:
- Speculative register alias table for the rename stage. Maps architectural registers to physical registers for a group of WIDTH instructions per cycle.
- Resolves intra-group RAW and WAW dependencies by bypassing younger lanes from older lanes.
- Adds a circular buffer of branch checkpoints. A mispredicted branch restores the map in one cycle; an in-order branch resolve releases the checkpoint.
- Sits between decode/free-list allocation and dispatch.

Parameters:
- WIDTH, 4, rename lanes per cycle; lane 0 is oldest.
- AREGS, 32, architectural registers; the index width AW is clog2(AREGS).
- PW, 6, physical register index width (64 physical registers).
- NCKPT, 4, checkpoint slots; must be a power of 2; the id width CW is clog2(NCKPT).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  a rename group is presented.
- in_ready  out  1  the group is accepted this cycle.
- rs1, rs2  in  WIDTH*AW  source architectural registers; lane i occupies bits [i*AW +: AW].
- dest  in  WIDTH*AW  destination architectural registers.
- dest_we  in  WIDTH  per-lane destination valid.
- new_preg  in  WIDTH*PW  per-lane allocated physical registers from the free list.
- prs1, prs2  out  WIDTH*PW  renamed sources (combinational).
- old_preg  out  WIDTH*PW  previous mapping of dest, sent to the ROB for freeing at commit (combinational).
- ckpt_req  in  1  take a checkpoint after this group.
- ckpt_id  out  CW  id allocated to the checkpoint requested this cycle (combinational; equals the tail pointer).
- ckpt_full  out  1  all NCKPT slots are in use.
- br_release  in  1  the oldest outstanding checkpoint resolved correctly; free it.
- br_restore  in  1  mispredict detected.
- br_id  in  CW  checkpoint to restore.

Behaviour:
- Reset:
  - map[i] = i for all i.
  - head = tail = 0, count = 0.
  - in_ready = 1 and ckpt_full = 0 once reset is released.
  - Reset asserted mid-operation discards all checkpoints and pending updates immediately.
- Register 0:
  - map[0] is hard-wired to 0 and never written.
  - Lookups of register 0 return 0.
  - A lane whose dest is 0 is treated as dest_we=0 for bypass purposes; its old_preg is 0.
- Source lookup, lane k:
  - prsX = new_preg of the highest lane j<k with dest_we[j]=1 and dest[j]=rsX (rsX≠0).
  - Otherwise prsX = map[rsX].
- Old mapping, lane k:
  - old_preg = new_preg of the highest lane j<k with dest_we[j]=1 and dest[j]=dest[k].
  - Otherwise old_preg = map[dest[k]].
- Map update, on the edge with in_valid && in_ready:
  - For every lane with dest_we=1 and dest≠0, write map[dest] = new_preg.
  - If several lanes share a dest, the highest lane wins.
- Handshake:
  - in_ready = !br_restore && !(ckpt_req && ckpt_full).
  - in_ready ignores in_valid; no output state changes when the group is not accepted.
- Checkpoint take, on the edge with in_valid && in_ready && ckpt_req:
  - slot[tail] = the map including this group's updates.
  - tail += 1 mod NCKPT; count += 1.
  - ckpt_id shows the tail pointer before the increment.
- Release, br_release with count>0:
  - head += 1; count -= 1.
  - br_release with count=0 is ignored.
- Restore, br_restore:
  - map = slot[br_id].
  - Slot br_id and all younger slots are freed: tail = br_id+1 mod NCKPT, count = (br_id - head mod NCKPT) + 1. Slot br_id stays valid, holding the post-branch state.
  - The group on the inputs is rejected (in_ready=0).
  - A br_id that is not outstanding is illegal.
- Simultaneous events:
  - Release and restore in the same cycle: release is applied first (head+1), then restore. br_id must not equal the head being released.
  - Release and take in the same cycle: both apply; count is unchanged.
  - Take while count=NCKPT: the group stalls. A release in the same cycle does not unstall it; ckpt_full is based on registered count.
- Pointer wrap-around is modulo NCKPT. ckpt_full = (count == NCKPT); count is CW+1 bits wide.
- Latency: lookups are zero-cycle; map and checkpoint state are visible the next cycle.

Test Plan:
- Reset then lookup: rs1=5, rs2=31 on lane 0 → prs1=5, prs2=31; rs1=0 → 0.
- Intra-group bypass: lane0 dest=3/new=40, lane2 dest=3/new=41, lane3 rs1=3, all we=1 → lane3 prs1=41; lane2 old_preg=40; next cycle map[3]=41.
- x0 protection: lane0 dest=0/new=50, lane1 rs1=0 → prs1=0, map[0] remains 0.
- Checkpoint/restore: group sets r4→44 with ckpt_req (ckpt_id=0); next group sets r4→45; br_restore br_id=0 → in_ready=0 that cycle; next cycle lookup r4=44, count=1.
- Full stall: take 4 checkpoints → ckpt_full=1; a 5th ckpt_req gives in_ready=0 and map unchanged; br_release → next cycle in_ready=1 and the take succeeds with ckpt_id=0 (wrap).
- Async reset mid-stream: assert rst between edges with count=3 and map[7]=60 → immediately map[7]=7, count=0, ckpt_full=0.
